// File: rtl/rd_stream_pkg.sv
// rtl/rd_stream_pkg.sv - shared types and default geometry for the DDR read-return stream stage
package rd_stream_pkg;

  localparam int DATA_W_DEF = 512;
  localparam int DEPTH_DEF  = 512;
  localparam int KEEP_W     = DATA_W_DEF / 8;
  localparam int CNT_W      = $clog2(DEPTH_DEF) + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO with occupancy level
module sync_fifo_fwft #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 512,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  level_q;
  logic              do_wr;
  logic              do_rd;

  assign full  = (level_q == CNT_W'(DEPTH));
  assign empty = (level_q == '0);

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = mem[rd_ptr];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/axi4_read_data_packetizer.sv
// rtl/axi4_read_data_packetizer.sv - DDR read beats to AXI4-Stream packets with watermark and drop accounting
module axi4_read_data_packetizer #(
  parameter int DATA_W   = 512,
  parameter int DEPTH    = 512,
  parameter int LEN_W    = 16,
  parameter int AFULL_TH = 448,
  parameter int DROP_W   = 32,
  localparam int KEEP_W  = DATA_W / 8,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ddr_rd_data,
  input  logic              ddr_rd_valid,
  input  logic [LEN_W-1:0]  cfg_pkt_beats,
  input  logic              clr_err,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic [KEEP_W-1:0] M_AXIS_TKEEP,
  output logic              M_AXIS_TVALID,
  output logic              M_AXIS_TLAST,
  input  logic              M_AXIS_TREADY,
  output logic              almost_full,
  output logic [CNT_W-1:0]  fifo_level,
  output logic              overflow_err,
  output logic [DROP_W-1:0] drop_count,
  output logic [15:0]       latest_data_monitor
);

  import rd_stream_pkg::*;

  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  level;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              drop;

  pkt_state_t        state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  bcnt;
  logic [LEN_W-1:0]  cfg_len;
  logic              last_beat;

  logic              err_q;
  logic [DROP_W-1:0] drop_q;
  logic [15:0]       mon_q;

  assign pop  = ~empty & M_AXIS_TREADY;
  assign push = ddr_rd_valid & (~full | pop);
  assign drop = ddr_rd_valid & full & ~pop;

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (ddr_rd_data),
    .wr_en   (push),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // A zero length means single-beat packets.
  assign cfg_len = (cfg_pkt_beats == '0) ? LEN_W'(1) : cfg_pkt_beats;

  always_comb begin
    last_beat = 1'b0;
    if (state == IDLE) begin
      last_beat = (cfg_len == LEN_W'(1));
    end else begin
      last_beat = (bcnt == len - LEN_W'(1));
    end
  end

  // Gate the head so the bus reads zero whenever nothing is presented.
  assign M_AXIS_TVALID = ~empty;
  assign M_AXIS_TDATA  = empty ? '0 : head;
  assign M_AXIS_TKEEP  = empty ? '0 : '1;
  assign M_AXIS_TLAST  = ~empty & last_beat;

  assign fifo_level          = level;
  assign almost_full         = (level >= CNT_W'(AFULL_TH));
  assign overflow_err        = err_q;
  assign drop_count          = drop_q;
  assign latest_data_monitor = mon_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      bcnt  <= '0;
    end else if (pop) begin
      if (state == IDLE) begin
        len   <= cfg_len;
        bcnt  <= LEN_W'(1);
        state <= last_beat ? IDLE : IN_PKT;
      end else begin
        bcnt <= bcnt + 1'b1;
        if (last_beat) state <= IDLE;
      end
    end
  end

  // A drop coinciding with a software clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      err_q <= 1'b1;
      if (clr_err)      drop_q <= DROP_W'(1);
      else if (~&drop_q) drop_q <= drop_q + 1'b1;
    end else if (clr_err) begin
      err_q  <= 1'b0;
      drop_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mon_q <= '0;
    end else if (pop) begin
      mon_q <= head[15:0];
    end
  end

endmodule
